multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle main control decoder.
- Sequences each MIPS instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables and muxes as Moore outputs of a registered state.
- Adds memory wait-state handshake, halfword-load control, optional jump, illegal-opcode detection and a retired-instruction counter.

Parameters:
- ENABLE_HALF, 1: 1 = lh (100001) and lhu (100101) legal; 0 = both illegal.
- ENABLE_JUMP, 1: 1 = j (000010) legal; 0 = illegal.
- WAIT_MEM, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from IR; sampled only in DECODE
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ld_half  out  1  halfword load select
- ld_signed  out  1  sign-extend loaded halfword
- illegal  out  1  unknown opcode seen in DECODE, this cycle
- err_sticky  out  1  set by illegal; cleared only by rst
- state  out  4  current state code, debug
- instr_count  out  CNT_W  retired instructions; wraps to 0

Behaviour:
- Async reset: state=IDLE, op_q=0, err_sticky=0, instr_count=0; every output 0.
- IDLE -> FETCH unconditionally on the next edge.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Outputs decode from state; any signal not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE:
  - Drives alu_src_b=11; latches opcode into op_q.
  - Next state by opcode: R -> EXEC; lw/lh/lhu/sw -> MEMADR; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other or disabled opcode: illegal=1 this cycle, err_sticky set, -> FETCH, no retire count.
- MEMADR: alu_src_a=1, alu_src_b=10. Stores go to MEMWR; loads go to MEMRD.
- MEMRD:
  - Drives i_or_d=1, mem_read=1.
  - Holds until mem_ready, then -> MEMWB.
- MEMWB:
  - Drives mem_to_reg=1, reg_write=1.
  - ld_half=1 for lh/lhu; ld_signed=1 for lw/lh.
  - -> FETCH.
- MEMWR:
  - Drives i_or_d=1, mem_write=1.
  - Holds until mem_ready, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> ALUWB.
- ALUWB: reg_dst=1, reg_write=1; -> FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_src=01; -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10; -> ADDIWB.
- ADDIWB: reg_write=1; -> FETCH.
- JUMP: pc_write=1, pc_src=10; -> FETCH.
- Retire rule:
  - instr_count += 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP.
  - The count wraps modulo 2^CNT_W.
- Unused state codes -> FETCH next cycle; counter and err_sticky unaffected.
- rst asserted mid-instruction: immediate return to IDLE, all outputs 0, counter cleared.
- Latency with mem_ready=1, in cycles: R 4, lw/lh/lhu 5, sw 4, beq 3, addi 4, j 3.

Decomposition:
- Package mc_pkg:
  - State codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12.
  - Opcode constants: OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_LH, OP_LHU, OP_J.
  - alu_src_b, alu_op and pc_src encodings.
- One sub-module, mc_out_decode: purely combinational state/op_q -> control-output map. The FSM, counter and sticky flag stay in the top.

Test Plan:
- rst high mid-MEMRD, then release -> all outputs 0 while high; IDLE, then FETCH; instr_count=0.
- R-type, mem_ready=1 -> state sequence 1,2,7,8,1; reg_dst=1 and reg_write=1 in ALUWB; instr_count 0->1.
- lh with mem_ready low for 3 cycles in MEMRD -> MEMRD held 3 extra cycles with mem_read=1; MEMWB shows ld_half=1, ld_signed=1. lhu gives ld_signed=0.
- sw then beq -> mem_write=1 only in MEMWR; BRANCH shows pc_write_cond=1, alu_op=01, pc_src=01; count +2.
- Opcode 111111, then ENABLE_JUMP=0 with j -> illegal pulses 1 cycle each; err_sticky=1 until rst; instr_count unchanged.
- CNT_W=4, 16 addi instructions -> instr_count wraps 15->0; each addi takes 4 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_t : FSM state codes (also exported on the 4-bit debug state port)
//   OP_*    : instruction[31:26] opcodes recognised by the decoder
//   SRCB_*, ALU_*, PC_* : datapath mux / ALU control encodings
//   ctrl_t  : bundle of all state-decoded datapath control outputs
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ld_half;
        logic       ld_signed;
    } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control-output map for the multi-cycle controller.
//   state  : current FSM state
//   op_q   : opcode latched in DECODE (selects halfword/sign load controls)
//   mem_ok : memory access completes this cycle (already gated by WAIT_MEM)
//   ctrl   : all datapath controls; anything not named for a state is 0
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       mem_ok,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                // IR and PC only update on the cycle the fetch completes.
                ctrl.ir_write  = mem_ok;
                ctrl.pc_write  = mem_ok;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.ld_half    = (op_q == OP_LH) || (op_q == OP_LHU);
                ctrl.ld_signed  = (op_q == OP_LW) || (op_q == OP_LH);
            end
            S_MEMWR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main controller: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath as Moore
// outputs of the registered state.
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   opcode           : instruction[31:26], only looked at in DECODE
//   mem_ready        : memory handshake (see below)
//   pc_write .. ld_signed : datapath controls (see mc_out_decode)
//   illegal          : unknown/disabled opcode seen in DECODE this cycle
//   err_sticky       : latched illegal, cleared only by rst
//   state            : current state code, debug
//   instr_count      : retired instructions, wraps modulo 2^CNT_W
//
// Memory handshake: the controller holds mem_read/mem_write (the request)
// steady in FETCH, MEMRD and MEMWR; the access completes on the first
// rising edge where mem_ready=1 in one of those states, and only then does
// the state advance. mem_ready is don't-care in every other state, and is
// treated as always 1 when WAIT_MEM=0.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter bit ENABLE_HALF = 1'b1,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter bit WAIT_MEM    = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             ld_half,
    output logic             ld_signed,
    output logic             illegal,
    output logic             err_sticky,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       op_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_ok;
    logic             op_legal;
    logic             decode_illegal;
    logic             retire;
    ctrl_t            ctrl;

    assign mem_ok = WAIT_MEM ? mem_ready : 1'b1;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_legal = 1'b1;
            OP_LH, OP_LHU:                       op_legal = ENABLE_HALF;
            OP_J:                                op_legal = ENABLE_JUMP;
            default:                             op_legal = 1'b0;
        endcase
    end

    assign decode_illegal = (state_q == S_DECODE) && !op_legal;

    // Next state plus the retire strobe, which marks every transition into
    // FETCH that completes an instruction (illegal decode does not retire).
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_R:                       state_d = S_EXEC;
                        OP_LW, OP_LH, OP_LHU, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:                     state_d = S_BRANCH;
                        OP_ADDI:                    state_d = S_ADDIEX;
                        OP_J:                       state_d = S_JUMP;
                        default:                    state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ok) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // Unused encodings recover without touching counter or flag.
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (decode_illegal)      err_q <= 1'b1;
            if (retire)              cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    mc_out_decode u_out_decode (
        .state  (state_q),
        .op_q   (op_q),
        .mem_ok (mem_ok),
        .ctrl   (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign ld_half       = ctrl.ld_half;
    assign ld_signed     = ctrl.ld_signed;
    assign illegal       = decode_illegal;
    assign err_sticky    = err_q;
    assign state         = state_q;
    assign instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Two instances: dut_a with default
// parameters, dut_b with halfword loads and jump disabled, WAIT_MEM=0 and a
// 4-bit counter. Only one is exercised at a time (the other is in reset).
// Per instruction the bench expands the expected cycle-by-cycle phases and
// pushes one expected output vector per cycle; a negedge process pops and
// compares. Literal checks pin counts and flags at key points.
module tb_multicycle_controller;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LH   = 6'b100001;
    localparam logic [5:0] T_LHU  = 6'b100101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [5:0] opcode;
    logic       mem_ready;

    logic a_pw, a_pwc, a_iod, a_mr, a_mw, a_irw, a_rd, a_m2r, a_rw, a_asa;
    logic a_lh, a_ls, a_ill, a_err;
    logic [1:0] a_asb, a_aop, a_psrc;
    logic [3:0] a_state;
    logic [15:0] a_cnt;

    logic b_pw, b_pwc, b_iod, b_mr, b_mw, b_irw, b_rd, b_m2r, b_rw, b_asa;
    logic b_lh, b_ls, b_ill, b_err;
    logic [1:0] b_asb, b_aop, b_psrc;
    logic [3:0] b_state;
    logic [3:0] b_cnt;

    multicycle_controller #(
        .ENABLE_HALF(1'b1), .ENABLE_JUMP(1'b1), .WAIT_MEM(1'b1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst_a), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(a_pw), .pc_write_cond(a_pwc), .i_or_d(a_iod), .mem_read(a_mr),
        .mem_write(a_mw), .ir_write(a_irw), .reg_dst(a_rd), .mem_to_reg(a_m2r),
        .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
        .pc_src(a_psrc), .ld_half(a_lh), .ld_signed(a_ls), .illegal(a_ill),
        .err_sticky(a_err), .state(a_state), .instr_count(a_cnt)
    );

    multicycle_controller #(
        .ENABLE_HALF(1'b0), .ENABLE_JUMP(1'b0), .WAIT_MEM(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(b_pw), .pc_write_cond(b_pwc), .i_or_d(b_iod), .mem_read(b_mr),
        .mem_write(b_mw), .ir_write(b_irw), .reg_dst(b_rd), .mem_to_reg(b_m2r),
        .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
        .pc_src(b_psrc), .ld_half(b_lh), .ld_signed(b_ls), .illegal(b_ill),
        .err_sticky(b_err), .state(b_state), .instr_count(b_cnt)
    );

    logic [23:0] act_a, act_b;
    assign act_a = {a_state, a_pw, a_pwc, a_iod, a_mr, a_mw, a_irw, a_rd, a_m2r,
                    a_rw, a_asa, a_asb, a_aop, a_psrc, a_lh, a_ls, a_ill, a_err};
    assign act_b = {b_state, b_pw, b_pwc, b_iod, b_mr, b_mw, b_irw, b_rd, b_m2r,
                    b_rw, b_asa, b_asb, b_aop, b_psrc, b_lh, b_ls, b_ill, b_err};

    // model state
    int         checks = 0;
    int         failures = 0;
    logic [39:0] exp_q[$];
    bit         sel_b = 1'b0;
    bit         cfg_wm = 1'b1, cfg_eh = 1'b1, cfg_ej = 1'b1;
    int         cnt_mod = 65536;
    int         m_cnt = 0;
    bit         m_err = 1'b0;
    logic [5:0] m_op = '0;

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            T_R, T_LW, T_SW, T_BEQ, T_ADDI: return 1'b1;
            T_LH, T_LHU:                    return cfg_eh;
            T_J:                            return cfg_ej;
            default:                        return 1'b0;
        endcase
    endfunction

    // Expected outputs for one cycle of a given phase (phase number is the
    // state code the debug port must show).
    function automatic logic [23:0] expv(input int ph, input logic [5:0] op,
                                         input logic rdy, input logic ill,
                                         input logic err);
        logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, lh, ls;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, lh, ls} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (ph)
            1:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1'b1; asb = 2'b10; end
            4:  begin iod = 1'b1; mr = 1'b1; end
            5:  begin
                    m2r = 1'b1; rw = 1'b1;
                    lh = (op == T_LH) || (op == T_LHU);
                    ls = (op == T_LW) || (op == T_LH);
                end
            6:  begin iod = 1'b1; mw = 1'b1; end
            7:  begin asa = 1'b1; aop = 2'b10; end
            8:  begin rd = 1'b1; rw = 1'b1; end
            9:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            12: begin pw = 1'b1; psrc = 2'b10; end
            default: ;
        endcase
        return {4'(ph), pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop,
                psrc, lh, ls, (ph == 2) && ill, err};
    endfunction

    // driver: drive one cycle and queue its expectation
    task automatic step(input int ph, input logic [5:0] opd, input logic rdy,
                        input bit ill);
        logic rdy_eff;
        opcode    = opd;
        mem_ready = rdy;
        rdy_eff   = cfg_wm ? rdy : 1'b1;
        exp_q.push_back({expv(ph, m_op, rdy_eff, ill, m_err), 16'(m_cnt)});
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input int ph, input int waits);
        if (cfg_wm) begin
            for (int i = 0; i < waits; i++) step(ph, rnd6(), 1'b0, 1'b0);
            step(ph, rnd6(), 1'b1, 1'b0);
        end else begin
            step(ph, rnd6(), 1'b0, 1'b0);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait);
        bit legal;
        legal = is_legal(op);
        mem_phase(1, fwait);
        m_op = op;
        step(2, op, rnd1(), !legal);
        if (!legal) begin
            m_err = 1'b1;
            return;
        end
        case (op)
            T_R:    begin step(7, rnd6(), rnd1(), 0); step(8, rnd6(), rnd1(), 0); end
            T_LW, T_LH, T_LHU: begin
                step(3, rnd6(), rnd1(), 0);
                mem_phase(4, mwait);
                step(5, rnd6(), rnd1(), 0);
            end
            T_SW:   begin step(3, rnd6(), rnd1(), 0); mem_phase(6, mwait); end
            T_BEQ:  step(9, rnd6(), rnd1(), 0);
            T_ADDI: begin step(10, rnd6(), rnd1(), 0); step(11, rnd6(), rnd1(), 0); end
            T_J:    step(12, rnd6(), rnd1(), 0);
            default: ;
        endcase
        m_cnt = (m_cnt + 1) % cnt_mod;
    endtask

    task automatic check_lit(input string name, input logic [31:0] act,
                             input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // scoreboard compare, every cycle a driver step queued an expectation
    always @(negedge clk) begin
        logic [39:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = sel_b ? {act_b, 12'd0, b_cnt} : {act_a, a_cnt};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL ctl_%s t=%0t actual=%h required=%h (state %0d vs %0d, count %0d vs %0d)",
                         sel_b ? "b" : "a", $time, a, e, a[39:36], e[39:36],
                         a[15:0], e[15:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; opcode = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // dut_a
        step(0, rnd6(), rnd1(), 0);
        rst_a = 1'b0;
        step(0, rnd6(), rnd1(), 0);
        check_lit("a_fetch_after_reset", a_state, 1);

        run_instr(T_R, 0, 0);
        check_lit("a_cnt_after_r", a_cnt, 1);
        run_instr(T_LH, 2, 3);
        run_instr(T_LHU, 0, 0);
        run_instr(T_SW, 0, 2);
        run_instr(T_BEQ, 0, 0);
        check_lit("a_cnt_after_beq", a_cnt, 5);
        check_lit("a_err_clear", a_err, 0);
        run_instr(T_ADDI, 0, 0);
        run_instr(T_J, 1, 0);
        run_instr(T_BAD, 0, 0);
        check_lit("a_err_set", a_err, 1);
        check_lit("a_cnt_after_bad", a_cnt, 7);
        run_instr(T_LW, 1, 1);
        check_lit("a_cnt_after_lw", a_cnt, 8);

        // reset in the middle of a stalled load
        mem_phase(1, 0);
        m_op = T_LW;
        step(2, T_LW, rnd1(), 0);
        step(3, rnd6(), rnd1(), 0);
        step(4, rnd6(), 1'b0, 0);
        step(4, rnd6(), 1'b0, 0);
        rst_a = 1'b1; m_cnt = 0; m_err = 1'b0;
        step(0, rnd6(), rnd1(), 0);
        step(0, rnd6(), rnd1(), 0);
        rst_a = 1'b0;
        step(0, rnd6(), rnd1(), 0);
        check_lit("a_state_after_rst", a_state, 1);
        check_lit("a_cnt_after_rst", a_cnt, 0);
        check_lit("a_err_after_rst", a_err, 0);
        run_instr(T_R, 0, 0);
        check_lit("a_cnt_after_r2", a_cnt, 1);

        // dut_b
        rst_a = 1'b1;
        sel_b = 1'b1; cfg_wm = 1'b0; cfg_eh = 1'b0; cfg_ej = 1'b0;
        cnt_mod = 16; m_cnt = 0; m_err = 1'b0;
        rst_b = 1'b0;
        step(0, rnd6(), rnd1(), 0);
        for (int i = 0; i < 15; i++) run_instr(T_ADDI, 0, 0);
        check_lit("b_cnt_15", b_cnt, 15);
        run_instr(T_ADDI, 0, 0);
        check_lit("b_cnt_wrap", b_cnt, 0);
        check_lit("b_err_clear", b_err, 0);
        run_instr(T_J, 0, 0);
        check_lit("b_err_after_j", b_err, 1);
        run_instr(T_LH, 0, 0);
        run_instr(T_LHU, 0, 0);
        check_lit("b_cnt_after_illegal", b_cnt, 0);
        run_instr(T_LW, 0, 3);
        run_instr(T_SW, 0, 3);
        check_lit("b_cnt_final", b_cnt, 2);
        check_lit("b_err_final", b_err, 1);
        check_lit("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
